// File: rtl/bc_pkg.sv
// Shared types and helpers for the two-player Bulls & Cows engine.
// The state encoding drives the external display block through state_o.
package bc_pkg;

  typedef enum logic [3:0] {
    StP1Setup = 4'd0,
    StP2Setup = 4'd1,
    StP1Guess = 4'd2,
    StP2Guess = 4'd3,
    StCheck   = 4'd4,
    StScore   = 4'd5,
    StShow    = 4'd6,
    StWin     = 4'd7,
    StDraw    = 4'd8
  } bc_state_t;

  localparam int unsigned MaxWordW  = 64;
  localparam int unsigned MaxDigitW = 8;

  localparam logic [MaxDigitW-1:0] NULL_DIGIT = '1;

  // Callers zero-extend their word to MaxWordW and truncate the result to their digit width.
  function automatic logic [MaxDigitW-1:0] get_digit(input logic [MaxWordW-1:0] word,
                                                     input int unsigned       idx,
                                                     input int unsigned       width);
    logic [MaxWordW-1:0] shifted;
    logic [MaxWordW-1:0] mask;
    if (width == 0 || width > MaxDigitW) return NULL_DIGIT;
    shifted = word >> (idx * width);
    mask    = (MaxWordW'(1) << width) - MaxWordW'(1);
    return MaxDigitW'(shifted & mask);
  endfunction

endpackage

// File: rtl/bc_scorer.sv
// Sequential bulls/cows scorer: walks one guess digit per cycle against the secret.
// bulls/cows/done are combinational so the final totals are ready on the last digit's cycle.
module bc_scorer
  import bc_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned CNT_W    = $clog2(N_DIGITS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [N_DIGITS*DIGIT_W-1:0] guess,
  input  logic [N_DIGITS*DIGIT_W-1:0] secret,
  output logic [CNT_W-1:0]            bulls,
  output logic [CNT_W-1:0]            cows,
  output logic                        done
);

  localparam int unsigned IdxW = $clog2(N_DIGITS);

  logic               active_q;
  logic [IdxW-1:0]    idx_q;
  logic [CNT_W-1:0]   bulls_acc_q;
  logic [CNT_W-1:0]   cows_acc_q;
  logic [DIGIT_W-1:0] g_dig;
  logic               bull_hit;
  logic               cow_hit;

  always_comb begin
    g_dig    = DIGIT_W'(get_digit(MaxWordW'(guess), 32'(idx_q), DIGIT_W));
    bull_hit = 1'b0;
    cow_hit  = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (g_dig == DIGIT_W'(get_digit(MaxWordW'(secret), j, DIGIT_W))) begin
        if (j == 32'(idx_q)) bull_hit = 1'b1;
        else                 cow_hit  = 1'b1;
      end
    end
  end

  assign done  = active_q && (32'(idx_q) == N_DIGITS - 1);
  assign bulls = bulls_acc_q + CNT_W'(active_q && bull_hit);
  assign cows  = cows_acc_q + CNT_W'(active_q && cow_hit && !bull_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q    <= 1'b0;
      idx_q       <= '0;
      bulls_acc_q <= '0;
      cows_acc_q  <= '0;
    end else if (start) begin
      active_q    <= 1'b1;
      idx_q       <= '0;
      bulls_acc_q <= '0;
      cows_acc_q  <= '0;
    end else if (active_q) begin
      bulls_acc_q <= bulls;
      cows_acc_q  <= cows;
      if (done) active_q <= 1'b0;
      else      idx_q    <= idx_q + IdxW'(1);
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Two-player Bulls & Cows controller: secret capture, legality check, turn
// alternation, round counting and win/draw detection. Display formatting lives elsewhere.
module bulls_cows_engine
  import bc_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned MAX_DIGIT  = 9,
  parameter int unsigned MAX_ROUNDS = 0,
  parameter int unsigned CNT_W      = $clog2(N_DIGITS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        confirma,
  input  logic [N_DIGITS*DIGIT_W-1:0] SW,
  output logic [3:0]                  state_o,
  output logic                        player_o,
  output logic [CNT_W-1:0]            bulls,
  output logic [CNT_W-1:0]            cows,
  output logic                        result_valid,
  output logic                        reject,
  output logic [7:0]                  round_o,
  output logic                        winner_valid,
  output logic                        winner,
  output logic                        draw
);

  localparam int unsigned WordW = N_DIGITS * DIGIT_W;

  bc_state_t          state_q, state_d, ret_q;
  logic [WordW-1:0]   cap_q, p1_secret_q, p2_secret_q;
  logic               player_q, winner_q, result_valid_q, reject_q;
  logic [CNT_W-1:0]   bulls_q, cows_q;
  logic [7:0]         round_q;
  logic [DIGIT_W-1:0] cap_digits [N_DIGITS];
  logic               legal, sc_start, sc_done, is_win, hits_limit;
  logic [CNT_W-1:0]   sc_bulls, sc_cows;

  always_comb begin
    legal = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      cap_digits[k] = DIGIT_W'(get_digit(MaxWordW'(cap_q), k, DIGIT_W));
    end
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (32'(cap_digits[k]) > MAX_DIGIT) legal = 1'b0;
      for (int unsigned j = k + 1; j < N_DIGITS; j++) begin
        if (cap_digits[k] == cap_digits[j]) legal = 1'b0;
      end
    end
  end

  assign sc_start   = (state_q == StCheck) && legal &&
                      (ret_q == StP1Guess || ret_q == StP2Guess);
  assign is_win     = (32'(bulls_q) == N_DIGITS);
  assign hits_limit = (MAX_ROUNDS != 0) && (32'(round_q) + 32'd1 == MAX_ROUNDS);

  // Each player's guess is scored against the opponent's secret.
  bc_scorer #(
    .N_DIGITS(N_DIGITS),
    .DIGIT_W (DIGIT_W),
    .CNT_W   (CNT_W)
  ) u_scorer (
    .clock (clock),
    .reset (reset),
    .start (sc_start),
    .guess (cap_q),
    .secret(player_q ? p1_secret_q : p2_secret_q),
    .bulls (sc_bulls),
    .cows  (sc_cows),
    .done  (sc_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= StP1Setup;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StP1Setup, StP2Setup, StP1Guess, StP2Guess: if (confirma) state_d = StCheck;
      StCheck: begin
        if (!legal)                 state_d = ret_q;
        else if (ret_q == StP1Setup) state_d = StP2Setup;
        else if (ret_q == StP2Setup) state_d = StP1Guess;
        else                        state_d = StScore;
      end
      StScore: if (sc_done) state_d = StShow;
      StShow: begin
        if (confirma) begin
          if (is_win)        state_d = StWin;
          else if (player_q) state_d = hits_limit ? StDraw : StP1Guess;
          else               state_d = StP2Guess;
        end
      end
      StWin, StDraw: if (confirma) state_d = StP1Setup;
      default: state_d = StP1Setup;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ret_q          <= StP1Setup;
      cap_q          <= '0;
      p1_secret_q    <= '0;
      p2_secret_q    <= '0;
      player_q       <= 1'b0;
      winner_q       <= 1'b0;
      bulls_q        <= '0;
      cows_q         <= '0;
      round_q        <= '0;
      result_valid_q <= 1'b0;
      reject_q       <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      unique case (state_q)
        StP1Setup, StP2Setup, StP1Guess, StP2Guess: begin
          if (confirma) begin
            cap_q <= SW;
            ret_q <= state_q;
          end
        end
        StCheck: begin
          if (!legal)                 reject_q    <= 1'b1;
          else if (ret_q == StP1Setup) p1_secret_q <= cap_q;
          else if (ret_q == StP2Setup) p2_secret_q <= cap_q;
        end
        StScore: begin
          if (sc_done) begin
            bulls_q        <= sc_bulls;
            cows_q         <= sc_cows;
            result_valid_q <= 1'b1;
          end
        end
        StShow: begin
          if (confirma) begin
            if (is_win) begin
              winner_q <= player_q;
            end else if (player_q) begin
              if (round_q != 8'hFF) round_q <= round_q + 8'd1;
              if (!hits_limit) player_q <= 1'b0;
            end else begin
              player_q <= 1'b1;
            end
          end
        end
        StWin, StDraw: begin
          if (confirma) begin
            p1_secret_q <= '0;
            p2_secret_q <= '0;
            round_q     <= '0;
            bulls_q     <= '0;
            cows_q      <= '0;
            winner_q    <= 1'b0;
            player_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_o      = state_q;
    player_o     = player_q;
    bulls        = bulls_q;
    cows         = cows_q;
    result_valid = result_valid_q;
    reject       = reject_q;
    round_o      = round_q;
    winner_valid = (state_q == StWin);
    winner       = winner_q;
    draw         = (state_q == StDraw);
  end

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Randomised bench for bulls_cows_engine against a game-level reference model.
module tb_bulls_cows_engine;
  import bc_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MD = 9;
  localparam int MR = 3;
  localparam int W  = N * DW;
  localparam int CW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          confirma;
  logic [W-1:0]  SW;
  logic [3:0]    state_o;
  logic          player_o;
  logic [CW-1:0] bulls, cows;
  logic          result_valid, reject;
  logic [7:0]    round_o;
  logic          winner_valid, winner, draw;

  int n_vec = 0;
  int n_bad = 0;

  bc_state_t    m_state;
  logic [W-1:0] m_p1, m_p2;
  logic         m_player, m_winner;
  int           m_round, m_bulls, m_cows;

  bulls_cows_engine #(
    .N_DIGITS  (N),
    .DIGIT_W   (DW),
    .MAX_DIGIT (MD),
    .MAX_ROUNDS(MR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .confirma    (confirma),
    .SW          (SW),
    .state_o     (state_o),
    .player_o    (player_o),
    .bulls       (bulls),
    .cows        (cows),
    .result_valid(result_valid),
    .reject      (reject),
    .round_o     (round_o),
    .winner_valid(winner_valid),
    .winner      (winner),
    .draw        (draw)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int digit_of(input logic [W-1:0] w, input int k);
    logic [W-1:0] t;
    t = w >> (k * DW);
    return int'(t[DW-1:0]);
  endfunction

  function automatic bit is_legal(input logic [W-1:0] w);
    for (int k = 0; k < N; k++) begin
      if (digit_of(w, k) > MD) return 1'b0;
      for (int j = 0; j < k; j++) if (digit_of(w, k) == digit_of(w, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic ref_score(input logic [W-1:0] g, input logic [W-1:0] s, output int b,
                           output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (digit_of(g, i) == digit_of(s, i)) b++;
      else for (int j = 0; j < N; j++) if (digit_of(g, i) == digit_of(s, j)) c++;
    end
  endtask

  function automatic logic [W-1:0] rand_legal();
    int           pool [MD+1];
    int           j, t;
    logic [W-1:0] w;
    for (int i = 0; i <= MD; i++) pool[i] = i;
    w = '0;
    for (int i = 0; i < N; i++) begin
      j       = int'($urandom_range(MD, i));
      t       = pool[i];
      pool[i] = pool[j];
      pool[j] = t;
      w       = w | (W'(pool[i]) << (i * DW));
    end
    return w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    if ($urandom_range(3, 0) == 0) return W'($urandom());
    return rand_legal();
  endfunction

  task automatic model_reset();
    m_state  = StP1Setup;
    m_p1     = '0;
    m_p2     = '0;
    m_player = 1'b0;
    m_winner = 1'b0;
    m_round  = 0;
    m_bulls  = 0;
    m_cows   = 0;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".state"}, 32'(state_o), 32'(m_state));
    check_eq({where, ".player"}, 32'(player_o), 32'(m_player));
    check_eq({where, ".round"}, 32'(round_o), 32'(m_round));
    check_eq({where, ".bulls"}, 32'(bulls), 32'(m_bulls));
    check_eq({where, ".cows"}, 32'(cows), 32'(m_cows));
    check_eq({where, ".winner_valid"}, 32'(winner_valid), 32'(m_state == StWin));
    check_eq({where, ".winner"}, 32'(winner), 32'(m_winner));
    check_eq({where, ".draw"}, 32'(draw), 32'(m_state == StDraw));
  endtask

  // Confirm a word from a SETUP/GUESS state and follow it through CHECK (and SCORE).
  task automatic enter_word(input logic [W-1:0] w, input bit poke);
    bc_state_t ret;
    int        b, c;
    ret      = m_state;
    SW       = w;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    check_eq("to_check", 32'(state_o), 32'(StCheck));
    tick();
    if (!is_legal(w)) begin
      check_eq("reject", 32'(reject), 32'd1);
      check_outputs("after_reject");
      return;
    end
    check_eq("no_reject", 32'(reject), 32'd0);
    if (ret == StP1Setup) begin
      m_p1    = w;
      m_state = StP2Setup;
      check_outputs("p1_setup");
    end else if (ret == StP2Setup) begin
      m_p2    = w;
      m_state = StP1Guess;
      check_outputs("p2_setup");
    end else begin
      ref_score(w, m_player ? m_p1 : m_p2, b, c);
      check_eq("in_score", 32'(state_o), 32'(StScore));
      for (int k = 1; k < N; k++) begin
        confirma = poke && (k == 1);
        tick();
        check_eq("rv_early", 32'(result_valid), 32'd0);
      end
      confirma = 1'b0;
      tick();
      m_bulls = b;
      m_cows  = c;
      m_state = StShow;
      check_eq("rv_pulse", 32'(result_valid), 32'd1);
      check_outputs("result");
      tick();
      check_eq("rv_drop", 32'(result_valid), 32'd0);
      check_outputs("show_hold");
    end
  endtask

  // Confirm from SHOW, WIN or DRAW.
  task automatic press();
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    if (m_state == StShow) begin
      if (m_bulls == N) begin
        m_state  = StWin;
        m_winner = m_player;
      end else if (m_player) begin
        if (MR != 0 && m_round + 1 == MR) m_state = StDraw;
        else begin
          m_state  = StP1Guess;
          m_player = 1'b0;
        end
        if (m_round < 255) m_round++;
      end else begin
        m_state  = StP2Guess;
        m_player = 1'b1;
      end
    end else begin
      model_reset();
    end
    check_outputs("press");
  endtask

  initial begin
    int guard;
    reset    = 1'b1;
    confirma = 1'b0;
    SW       = '0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check_outputs("reset");
    check_eq("reset.rv", 32'(result_valid), 32'd0);
    check_eq("reset.reject", 32'(reject), 32'd0);

    // Setup rejects, then a full scored game ending in a P2 win.
    enter_word(16'h1123, 1'b0);
    enter_word(16'h12A4, 1'b0);
    enter_word(16'h1234, 1'b0);
    enter_word(16'h5678, 1'b0);
    enter_word(16'h8765, 1'b0);
    press();
    enter_word(16'h1243, 1'b1);
    press();
    enter_word(16'h5679, 1'b0);
    press();
    enter_word(16'h1234, 1'b0);
    press();
    press();

    // Three missed rounds hit the round limit.
    enter_word(16'h1234, 1'b0);
    enter_word(16'h5678, 1'b0);
    for (int r = 0; r < MR; r++) begin
      enter_word(16'h9012, 1'b0);
      press();
      enter_word(16'h5678, 1'b0);
      press();
    end
    press();

    // Reset in the middle of scoring, with an ignored confirm beforehand.
    enter_word(16'h1234, 1'b0);
    enter_word(16'h5678, 1'b0);
    SW       = 16'h5678;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    tick();
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    check_eq("mid_score", 32'(state_o), 32'(StScore));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_outputs("mid_reset");
    check_eq("mid_reset.rv", 32'(result_valid), 32'd0);
    tick();
    check_eq("mid_reset.rv2", 32'(result_valid), 32'd0);
    check_outputs("mid_reset2");

    // Random games.
    for (int g = 0; g < 25; g++) begin
      guard = 0;
      while (m_state != StP1Guess && guard < 40) begin
        guard++;
        enter_word(rand_word(), 1'b0);
      end
      while (m_state != StWin && m_state != StDraw && guard < 80) begin
        guard++;
        if (m_state == StShow) press();
        else if ($urandom_range(3, 0) == 0) enter_word(m_player ? m_p1 : m_p2, 1'b0);
        else enter_word(rand_word(), $urandom_range(1, 0) == 1);
      end
      if (guard >= 80) check_eq("game_end", 32'(state_o), 32'(StWin));
      press();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
